// File: rtl/fifo_pkg.sv
// ============================================================
// fifo_pkg : shared widths and state encoding for the packer
// Rev 1.0
// ============================================================
`default_nettype none

package fifo_pkg;
    localparam int unsigned LANE_W     = 16;
    localparam int unsigned LANES      = 8;
    localparam int unsigned WORD_W     = 128;
    localparam int unsigned LANE_CNT_W = 3;

    typedef enum logic [0:0] {
        ACC   = 1'b0,
        FLUSH = 1'b1
    } state_e;
endpackage

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================
// fifo_word_packer : packs 16-bit lanes into 128-bit FIFO words
// Rev 1.0
// ============================================================
`default_nettype none

module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter logic [LANE_W-1:0] PAD_VALUE      = 16'h0000,
    parameter bit                USE_ALMOSTFULL = 1'b1
) (
    input  logic              ifclk,
    input  logic              reset,
    input  logic [LANE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [WORD_W-1:0] DI,
    output logic              WREN,
    input  logic              FULL,
    input  logic              ALMOSTFULL,
    output logic [31:0]       words_written
);

    state_e                  state_q, state_d;
    logic [LANE_CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0]       acc_q, acc_d;
    logic [WORD_W-1:0]       hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic                    flush_done_q, flush_done_d;
    logic [31:0]             words_written_q, words_written_d;

    logic                    hold_free;
    logic                    xfer;

    // Hold is usable when empty or when its word leaves this very cycle.
    assign hold_free = !hold_valid_q || !FULL;

    assign WREN          = hold_valid_q && !FULL && !reset;
    assign DI            = reset ? '0 : hold_q;
    assign flush_done    = flush_done_q && !reset;
    assign words_written = words_written_q;

    assign din_ready = !reset && (state_q == ACC)
                     && !(USE_ALMOSTFULL && ALMOSTFULL)
                     && ((lane_cnt_q != 3'd7) || hold_free);

    assign xfer = din_valid && din_ready;

    always_comb begin
        state_d         = state_q;
        lane_cnt_d      = lane_cnt_q;
        acc_d           = acc_q;
        hold_d          = hold_q;
        hold_valid_d    = hold_valid_q && !WREN;
        flush_done_d    = 1'b0;
        words_written_d = words_written_q + {31'd0, WREN};

        case (state_q)
            ACC: begin
                if (xfer) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (i == int'(lane_cnt_q)) acc_d[i*LANE_W +: LANE_W] = din;
                    end
                    if (lane_cnt_q == 3'd7) begin
                        hold_d       = acc_d;
                        hold_valid_d = 1'b1;
                    end
                    lane_cnt_d = lane_cnt_q + 3'd1;
                end
                // The flush sees the lane count after any same-cycle transfer.
                if (flush) begin
                    if (lane_cnt_d == '0) flush_done_d = 1'b1;
                    else                  state_d      = FLUSH;
                end
            end
            FLUSH: begin
                if (hold_free) begin
                    for (int i = 0; i < LANES; i++) begin
                        hold_d[i*LANE_W +: LANE_W] = (i >= int'(lane_cnt_q))
                                                   ? PAD_VALUE
                                                   : acc_q[i*LANE_W +: LANE_W];
                    end
                    hold_valid_d = 1'b1;
                    acc_d        = '0;
                    lane_cnt_d   = '0;
                    flush_done_d = 1'b1;
                    state_d      = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state_q         <= ACC;
            lane_cnt_q      <= '0;
            acc_q           <= '0;
            hold_q          <= '0;
            hold_valid_q    <= 1'b0;
            flush_done_q    <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            lane_cnt_q      <= lane_cnt_d;
            acc_q           <= acc_d;
            hold_q          <= hold_d;
            hold_valid_q    <= hold_valid_d;
            flush_done_q    <= flush_done_d;
            words_written_q <= words_written_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================
// tb_fifo_word_packer : directed + streamed scoreboard bench
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fifo_word_packer;

    logic         ifclk;
    logic         reset;
    logic [15:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic         flush;
    logic         flush_done;
    logic [127:0] DI;
    logic         WREN;
    logic         FULL;
    logic         ALMOSTFULL;
    logic [31:0]  words_written;

    logic         din_ready_n;
    logic         flush_done_n;
    logic [127:0] DI_n;
    logic         WREN_n;
    logic [31:0]  words_written_n;

    int checks   = 0;
    int failures = 0;
    int wren_cnt = 0;

    logic [127:0] exp_q[$];
    logic [127:0] model_acc;
    int           model_lane;
    bit           rand_full;

    fifo_word_packer #(.PAD_VALUE(16'hFFFF), .USE_ALMOSTFULL(1'b1)) dut (
        .ifclk(ifclk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .flush(flush), .flush_done(flush_done),
        .DI(DI), .WREN(WREN), .FULL(FULL), .ALMOSTFULL(ALMOSTFULL),
        .words_written(words_written)
    );

    fifo_word_packer #(.PAD_VALUE(16'h0000), .USE_ALMOSTFULL(1'b0)) dut_naf (
        .ifclk(ifclk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_n), .flush(flush), .flush_done(flush_done_n),
        .DI(DI_n), .WREN(WREN_n), .FULL(FULL), .ALMOSTFULL(ALMOSTFULL),
        .words_written(words_written_n)
    );

    initial ifclk = 1'b0;
    always #5 ifclk = ~ifclk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write is matched against the model.
    always @(negedge ifclk) begin
        if (!reset && WREN) begin
            wren_cnt++;
            chk("wren_while_full", {127'd0, FULL}, 128'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wren", DI, 128'hx);
            end else begin
                chk("di_word", DI, exp_q.pop_front());
            end
        end
    end

    task automatic model_accept(input logic [15:0] w);
        model_acc[model_lane*16 +: 16] = w;
        if (model_lane == 7) begin
            exp_q.push_back(model_acc);
            model_lane = 0;
        end else begin
            model_lane++;
        end
    endtask

    task automatic push(input logic [15:0] w);
        logic ok;
        bit   done;
        done = 0;
        din       = w;
        din_valid = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            if (rand_full) FULL = ($urandom_range(0, 2) == 0);
            @(negedge ifclk);
            ok = din_ready;
            @(posedge ifclk);
            #1;
            if (ok) begin
                model_accept(w);
                done = 1;
            end
        end
        din_valid = 1'b0;
        if (!done) chk("push_timeout", 128'd1, 128'd0);
    endtask

    task automatic do_flush(input int exp_cycles);
        int  n;
        bit  seen;
        seen = 0;
        flush = 1'b1;
        @(posedge ifclk);
        #1;
        flush = 1'b0;
        if (model_lane > 0) begin
            for (int i = model_lane; i < 8; i++) model_acc[i*16 +: 16] = 16'hFFFF;
            exp_q.push_back(model_acc);
            model_lane = 0;
        end
        for (n = 1; n <= 10 && !seen; n++) begin
            @(negedge ifclk);
            if (flush_done) begin
                seen = 1;
                chk("flush_done_latency", 128'(n), 128'(exp_cycles));
                if (exp_cycles > 1) chk("flush_wren_with_done", {127'd0, WREN}, 128'd1);
                else                chk("noop_flush_no_wren", {127'd0, WREN}, 128'd0);
            end
        end
        if (!seen) chk("flush_done_timeout", 128'd1, 128'd0);
        @(posedge ifclk);
        #1;
        chk("flush_done_one_cycle", {127'd0, flush_done}, 128'd0);
    endtask

    task automatic drain();
        int n;
        rand_full = 0;
        FULL      = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge ifclk);
            #1;
            n++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] word_a;
        int           w0;

        reset = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0;
        FULL = 1'b0; ALMOSTFULL = 1'b0; rand_full = 0;
        model_acc = '0; model_lane = 0;

        repeat (2) @(posedge ifclk);
        @(negedge ifclk);
        chk("rst_wren",       {127'd0, WREN},       128'd0);
        chk("rst_din_ready",  {127'd0, din_ready},  128'd0);
        chk("rst_flush_done", {127'd0, flush_done}, 128'd0);
        chk("rst_di",         DI,                   128'd0);
        @(posedge ifclk);
        #1;
        reset = 1'b0;
        @(negedge ifclk);
        chk("post_rst_count", 128'(words_written), 128'd0);
        chk("post_rst_ready", {127'd0, din_ready},  128'd1);
        @(posedge ifclk);
        #1;

        // Eight sequential lanes, then one-cycle write latency.
        for (int i = 1; i <= 8; i++) push(16'(i));
        chk("first_word_model", exp_q[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        @(negedge ifclk);
        chk("latency_wren", {127'd0, WREN}, 128'd1);
        drain();
        chk("count_after_one", 128'(words_written), 128'd1);

        // Partial word padded by a flush.
        push(16'h00A1); push(16'h00A2); push(16'h00A3);
        chk("flush_word_model", exp_q.size() == 0 ? 128'd0 : 128'd1, 128'd0);
        do_flush(2);
        drain();
        chk("count_after_flush", 128'(words_written), 128'd2);

        // Flush on an empty accumulator is a no-op.
        do_flush(1);
        chk("count_after_noop", 128'(words_written), 128'd2);

        // Backpressure: completed word held while FULL.
        FULL = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h1100 + 16'(i));
        word_a = 128'h1107_1106_1105_1104_1103_1102_1101_1100;
        for (int i = 0; i < 7; i++) push(16'h2200 + 16'(i));
        din = 16'h2207;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ifclk);
            chk("full_wren_low",  {127'd0, WREN},      128'd0);
            chk("full_lane7_rdy", {127'd0, din_ready}, 128'd0);
            chk("full_di_stable", DI,                  word_a);
        end
        @(posedge ifclk);
        #1;
        FULL = 1'b0;
        push(16'h2207);
        drain();
        chk("count_after_full", 128'(words_written), 128'd4);

        // ALMOSTFULL gates din_ready only when enabled.
        ALMOSTFULL = 1'b1;
        @(negedge ifclk);
        chk("af_ready_low",      {127'd0, din_ready},   128'd0);
        chk("af_disabled_ready", {127'd0, din_ready_n}, 128'd1);
        @(posedge ifclk);
        #1;
        ALMOSTFULL = 1'b0;
        @(negedge ifclk);
        chk("af_release_ready", {127'd0, din_ready}, 128'd1);
        @(posedge ifclk);
        #1;

        // Reset mid-word discards the partial data.
        for (int i = 0; i < 5; i++) push(16'hDEAD);
        reset = 1'b1;
        @(negedge ifclk);
        chk("midrst_wren",  {127'd0, WREN},      128'd0);
        chk("midrst_ready", {127'd0, din_ready}, 128'd0);
        chk("midrst_di",    DI,                  128'd0);
        @(posedge ifclk);
        #1;
        reset = 1'b0;
        model_acc = '0;
        model_lane = 0;
        w0 = wren_cnt;
        for (int i = 0; i < 8; i++) push(16'h3300 + 16'(i));
        chk("fresh_word_model", exp_q[0], 128'h3307_3306_3305_3304_3303_3302_3301_3300);
        drain();
        chk("midrst_one_wren", 128'(wren_cnt - w0), 128'd1);
        chk("midrst_count",    128'(words_written), 128'd1);

        // Long stream with random valid gaps and random FULL.
        w0 = wren_cnt;
        rand_full = 1;
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                FULL = ($urandom_range(0, 2) == 0);
                @(posedge ifclk);
                #1;
            end
            push(16'(i) ^ 16'hA5C3);
        end
        drain();
        chk("stream_wrens", 128'(wren_cnt - w0), 128'd128);
        chk("stream_count", 128'(words_written), 128'd129);

        repeat (2) @(posedge ifclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter PAD_VALUE, default 16'h0000: fill value for unused lanes on flush.
REQ-002 SHALL have parameter USE_ALMOSTFULL, default 1: 1 = ALMOSTFULL throttles din_ready.
REQ-003 SHALL have port ifclk  input  1: single clock; also drives the downstream FIFO WRCLK.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port din  input  16: host data lane.
REQ-006 SHALL have port din_valid  input  1: din carries a word.
REQ-007 SHALL have port din_ready  output  1: packer accepts din this cycle.
REQ-008 SHALL have port flush  input  1: single-cycle request to emit a partial word.
REQ-009 SHALL have port flush_done  output  1: one-cycle pulse when the flush completes.
REQ-010 SHALL have port DI  output  128: word to the 128-bit FIFO input.
REQ-011 SHALL have port WREN  output  1: FIFO write enable.
REQ-012 SHALL have port FULL  input  1: FIFO full flag.
REQ-013 SHALL have port ALMOSTFULL  input  1: FIFO almost-full flag, OR of both halves.
REQ-014 SHALL have port words_written  output  32: count of 128-bit words written, wrapping.

Function
REQ-015 A transfer SHALL occur when din_valid && din_ready; the n-th transfer of a word (lane_cnt = n, 0..7) SHALL land in accumulator bits [16n+15:16n].
REQ-016 On the transfer at lane_cnt=7, the completed word SHALL move to the hold register, hold_valid SHALL be set at the next edge, and lane_cnt SHALL wrap to 0.
REQ-017 DI SHALL equal the hold register; WREN SHALL be hold_valid && !FULL (combinational); hold_valid SHALL clear after a WREN cycle unless it is reloaded in the same cycle.
REQ-018 Latency SHALL be: 8th lane accepted at edge k -> WREN high in cycle k+1 when FULL=0.
REQ-019 din_ready SHALL be !reset && state==ACC && !(USE_ALMOSTFULL && ALMOSTFULL) && (lane_cnt!=7 || !hold_valid || !FULL).
REQ-020 The block SHALL have two states: ACC and FLUSH.
REQ-021 A flush in ACC with post-transfer lane_cnt=0 SHALL be a no-op, with flush_done pulsed at the next edge.
REQ-022 A flush in ACC with post-transfer lane_cnt>0 SHALL cause a transition to FLUSH.
REQ-023 In FLUSH, lanes lane_cnt..7 SHALL be filled with PAD_VALUE and the word loaded into hold once hold is free or draining; the block SHALL then go to ACC, set lane_cnt=0 and pulse flush_done.
REQ-024 A flush coinciding with a transfer SHALL include that transfer before the flush is evaluated; a transfer that completes the word SHALL make the flush a no-op.
REQ-025 flush while in FLUSH SHALL be ignored; din_ready SHALL be 0 in FLUSH.
REQ-026 words_written SHALL increment by 1 on every WREN cycle and wrap from 32'hFFFFFFFF to 0.
REQ-027 No word SHALL ever be dropped or duplicated: WREN SHALL never be high while FULL=1.

Reset
REQ-028 reset SHALL force state=ACC, lane_cnt=0, hold_valid=0, accumulator=0, words_written=0.
REQ-029 During reset, WREN=0, din_ready=0, flush_done=0 and DI=0.
REQ-030 Reset mid-word or mid-flush SHALL discard the partial data without a write.

Structure
REQ-031 Shared package fifo_pkg SHALL hold LANE_W=16, LANES=8, WORD_W=128 and the state enum {ACC, FLUSH}.
REQ-032 The block SHALL be a single module with no sub-module; the accumulator and hold register are local.

Verification
REQ-033 Feed 8 words 16'h0001..16'h0008 with FULL=0 -> one WREN, DI=128'h0008_0007_0006_0005_0004_0003_0002_0001, words_written=1.
REQ-034 Feed 3 words 16'hA1,16'hA2,16'hA3, then flush, PAD_VALUE=16'hFFFF -> DI upper 80 bits all 1s, lower 48 bits 00A3_00A2_00A1, flush_done one cycle after WREN load.
REQ-035 FULL=1 held for 10 cycles after a word completes -> WREN=0 throughout, din_ready=0 at lane 7; FULL drop -> single WREN with unchanged DI.
REQ-036 ALMOSTFULL=1 -> din_ready=0 the same cycle; USE_ALMOSTFULL=0 -> din_ready unaffected.
REQ-037 Assert reset after 5 lanes, then feed 8 fresh words -> exactly one WREN containing only the fresh words, words_written=1.
REQ-038 Stream 1024 words with random din_valid and FULL -> 128 WRENs, data in order, none while FULL=1.
